// File: rtl/buf_rd_ctrl_128x64_pkg.sv
// rtl/buf_rd_ctrl_128x64_pkg.sv - shared widths, FSM states and length clamp for the buffer read controller
package buf_rd_ctrl_128x64_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int WORD_W      = PIXEL_WIDTH * 8;
    localparam int BUF_DEPTH   = 128;
    localparam int BUF_AW      = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A run can never cover more than the whole buffer once.
    function automatic logic [7:0] clamp_len(input logic [7:0] len);
        return (len > 8'(BUF_DEPTH)) ? 8'(BUF_DEPTH) : len;
    endfunction

endpackage

// File: rtl/buf_skid_fifo2.sv
// rtl/buf_skid_fifo2.sv - 2-entry register FIFO catching RAM read data under backpressure
module buf_skid_fifo2
    import buf_rd_ctrl_128x64_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        cnt_o,
    output logic [WORD_W-1:0] head_o,
    output logic              valid_o
);

    logic [WORD_W-1:0] mem0_q, mem0_d;
    logic [WORD_W-1:0] mem1_q, mem1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pop_ok;

    assign pop_ok  = pop_i & (cnt_q != 2'd0);
    assign valid_o = (cnt_q != 2'd0);
    assign cnt_o   = cnt_q;
    assign head_o  = mem0_q;

    always_comb begin
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        cnt_d  = cnt_q;
        case ({push_i, pop_ok})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    mem0_d = push_data_i;
                    cnt_d  = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    mem1_d = push_data_i;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    mem0_d = mem1_q;
                end
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new word lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    mem0_d = push_data_i;
                end else begin
                    mem0_d = mem1_q;
                    mem1_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q <= '0;
            mem1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/buf_rd_ctrl_128x64.sv
// rtl/buf_rd_ctrl_128x64.sv - RAM port arbiter and credit-based read sequencer for the 128x64 buffer
module buf_rd_ctrl_128x64
    import buf_rd_ctrl_128x64_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [BUF_AW-1:0] base_i,
    input  logic [7:0]        len_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              wr_en_i,
    input  logic [BUF_AW-1:0] wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [BUF_AW-1:0] ram_addr_o,
    output logic [WORD_W-1:0] ram_data_o,
    input  logic [WORD_W-1:0] ram_data_i
);

    state_e            state_q, state_d;
    logic [BUF_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [BUF_AW-1:0] ram_addr_q, ram_addr_d;
    logic [WORD_W-1:0] ram_data_q, ram_data_d;
    logic [7:0]        issue_left_q, issue_left_d;
    logic [7:0]        pop_left_q, pop_left_d;
    logic              inflight_q;
    logic              zero_done_q, zero_done_d;
    logic [7:0]        len_eff;
    logic [1:0]        fifo_cnt;
    logic [2:0]        occ;
    logic              pop, wr_go, credit, rd_issue, running;

    assign running  = (state_q == ST_RUN);
    assign pop      = rd_valid_o & rd_ready_i;
    // Writes are masked while reset is held so every RAM pin reads 0 during reset.
    assign wr_go    = wr_en_i & rst_n;
    assign occ      = {1'b0, fifo_cnt} + {2'b00, inflight_q};
    assign credit   = (occ < 3'd2) | (pop & (occ == 3'd2));
    assign rd_issue = running & (issue_left_q != 8'd0) & ~wr_go & credit;
    assign busy_o   = running | zero_done_q;
    assign done_o   = zero_done_q | (running & pop & (pop_left_q == 8'd1));

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        zero_done_d  = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        len_eff      = 8'd0;
        ram_ce_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_addr_o   = ram_addr_q;
        ram_data_o   = ram_data_q;

        if (wr_go) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = 1'b1;
            ram_addr_o = wr_addr_i;
            ram_data_o = wr_data_i;
            ram_addr_d = wr_addr_i;
            ram_data_d = wr_data_i;
        end else if (rd_issue) begin
            ram_ce_o     = 1'b1;
            ram_addr_o   = rd_ptr_q;
            ram_addr_d   = rd_ptr_q;
            rd_ptr_d     = rd_ptr_q + 7'd1;
            issue_left_d = issue_left_q - 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i && !busy_o) begin
                    len_eff      = clamp_len(len_i);
                    rd_ptr_d     = base_i;
                    issue_left_d = len_eff;
                    pop_left_d   = len_eff;
                    if (len_eff == 8'd0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (pop) begin
                    pop_left_d = pop_left_q - 8'd1;
                    if (pop_left_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rd_ptr_q     <= '0;
            issue_left_q <= 8'd0;
            pop_left_q   <= 8'd0;
            inflight_q   <= 1'b0;
            zero_done_q  <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            inflight_q   <= rd_issue;
            zero_done_q  <= zero_done_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
        end
    end

    buf_skid_fifo2 u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (ram_data_i),
        .pop_i       (pop),
        .cnt_o       (fifo_cnt),
        .head_o      (rd_data_o),
        .valid_o     (rd_valid_o)
    );

endmodule
